hdlc_rx_deframer: RTL and testbench

- Parametrised HDLC receive deframer: serial bit stream in, framed words out.
- Per accepted bit it removes stuffed zeros, detects flags and aborts, and assembles LSB-first words.
- Adds per-frame start/end status with length and alignment checks.
- Sits between the line bit-sync and the frame buffer/CRC checker.

---
 rtl/hdlc_pkg.sv | 28 ++
 rtl/hdlc_rx_window.sv | 62 ++++++
 rtl/hdlc_rx_deframer.sv | 140 ++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive path: FSM state encoding,
// window length and the flag pattern generator.
package hdlc_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    FRAME
  } state_t;

  localparam int DEF_RUN_LEN = 5;
  // Window length for the default run length: 0, RUN_LEN+1 ones, 0.
  localparam int L = DEF_RUN_LEN + 3;
  localparam int PAT_MAX = 32;

  function automatic int win_len(input int run_len);
    return run_len + (L - DEF_RUN_LEN);
  endfunction

  // Flag pattern with a zero at each end and RUN_LEN+1 ones between.
  function automatic logic [PAT_MAX-1:0] flag_pattern(input int run_len);
    logic [PAT_MAX-1:0] p;
    p = '0;
    for (int i = 1; i <= run_len + 1; i++) p[i] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/hdlc_rx_window.sv
// Bit-level front end: ones-run tracking, stuffed-zero removal, abort detection
// and the tagged shift window that spots flags and releases delayed data bits.
module hdlc_rx_window
  import hdlc_pkg::*;
#(
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in,
  output logic exit_val,
  output logic exit_valid,
  output logic flag_det,
  output logic disc,
  output logic abort_det
);

  localparam int WL = win_len(RUN_LEN);
  localparam int RW = $clog2(RUN_LEN + 3);
  localparam logic [WL-1:0] FLAG      = WL'(flag_pattern(RUN_LEN));
  localparam logic [RW-1:0] RUN_STUFF = RW'(RUN_LEN);
  localparam logic [RW-1:0] RUN_PRE   = RW'(RUN_LEN + 1);
  localparam logic [RW-1:0] RUN_ABORT = RW'(RUN_LEN + 2);

  logic [RW-1:0] ones_run;
  logic [WL-1:0] win_val;
  logic [WL-1:0] win_tag;
  logic [WL-1:0] win_next;
  logic          step;

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    disc       = in_valid && !in && (ones_run == RUN_STUFF);
    step       = in_valid && !disc;
    win_next   = {win_val[WL-2:0], in};
    flag_det   = step && (win_next == FLAG);
    exit_val   = win_val[WL-1];
    exit_valid = step && win_tag[WL-1];
    abort_det  = in_valid && in && (ones_run == RUN_PRE);
  end

  // NOTE: non-blocking assignments for all state so every register sees
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_run <= '0;
      // NOTE: the window is reset to all ones (not zero) so stale reset
      // contents can never complete a flag with the first received bits.
      win_val  <= '1;
      win_tag  <= '0;
    end else if (in_valid) begin
      if (!in) ones_run <= '0;
      else if (ones_run != RUN_ABORT) ones_run <= ones_run + 1'b1;
      if (step) begin
        win_val <= win_next;
        win_tag <= flag_det ? '0 : {win_tag[WL-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: frame state machine, LSB-first word assembler and
// per-frame length/alignment status on top of the bit-level window.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int RUN_LEN   = DEF_RUN_LEN,
  parameter int WORD_W    = 8,
  parameter int MIN_WORDS = 2,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              flag,
  output logic              disc,
  output logic              eof,
  output logic              eof_ok,
  output logic              abort
);

  localparam int BW = $clog2(WORD_W);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [CW-1:0] WORD_MAX = CW'(MAX_WORDS);
  localparam logic [CW-1:0] WORD_MIN = CW'(MIN_WORDS);

  logic exit_val, exit_valid, flag_det, disc_det, abort_det;

  hdlc_rx_window #(.RUN_LEN(RUN_LEN)) u_window (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (in),
    .exit_val   (exit_val),
    .exit_valid (exit_valid),
    .flag_det   (flag_det),
    .disc       (disc_det),
    .abort_det  (abort_det)
  );

  state_t            state, state_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [CW-1:0]     word_cnt, word_cnt_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic              take, word_done, oversize, emit, close;

  logic [WORD_W-1:0] out_data_n;
  logic              out_valid_n, out_sof_n, flag_n, disc_n, eof_n, eof_ok_n, abort_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      word_cnt <= word_cnt_n;
      shreg    <= shreg_n;
    end
  end

  // Exiting data bit is assembled first; flag, oversize and abort then override.
  always_comb begin
    take       = exit_valid && !abort_det && (state != HUNT);
    word_done  = take && (bit_cnt == BIT_LAST);
    oversize   = word_done && (word_cnt == WORD_MAX);
    emit       = word_done && !oversize;
    close      = flag_det && !oversize && ((state == FRAME) || take);
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    shreg_n    = shreg;
    if (take) begin
      shreg_n[bit_cnt] = exit_val;
      state_n          = FRAME;
      if (word_done) begin
        bit_cnt_n  = '0;
        word_cnt_n = word_cnt + 1'b1;
      end else begin
        bit_cnt_n = bit_cnt + 1'b1;
      end
    end
    if (oversize) begin
      state_n    = HUNT;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
    end
    if (flag_det) begin
      state_n    = SYNC;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
    end
    if (abort_det) begin
      state_n    = HUNT;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
    end
  end

  always_comb begin
    out_data_n  = emit ? {exit_val, shreg[WORD_W-2:0]} : out_data;
    out_valid_n = emit;
    out_sof_n   = emit && (word_cnt == '0);
    flag_n      = flag_det;
    disc_n      = disc_det;
    abort_n     = abort_det && (state == FRAME);
    eof_n       = oversize || close;
    eof_ok_n    = close && (take ? word_done : (bit_cnt == '0))
                  && ((word_cnt + CW'(emit)) >= WORD_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      flag      <= 1'b0;
      disc      <= 1'b0;
      eof       <= 1'b0;
      eof_ok    <= 1'b0;
      abort     <= 1'b0;
    end else begin
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_sof   <= out_sof_n;
      flag      <= flag_n;
      disc      <= disc_n;
      eof       <= eof_n;
      eof_ok    <= eof_ok_n;
      abort     <= abort_n;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed self-checking bench for hdlc_rx_deframer with default parameters.
module tb_hdlc_rx_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sof, flag, disc, eof, eof_ok, abort;

  int checks = 0;
  int failures = 0;
  bit gap_mode = 1'b0;

  hdlc_rx_deframer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .flag      (flag),
    .disc      (disc),
    .eof       (eof),
    .eof_ok    (eof_ok),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  // Output monitor: logs words and eofs, counts strobes.
  logic [7:0] wdata_log [0:255];
  logic       wsof_log  [0:255];
  int         wcyc_log  [0:255];
  logic       eok_log   [0:255];
  int         ecyc_log  [0:255];
  int word_n = 0, eof_n = 0, flag_n = 0, disc_n = 0, abort_n = 0, cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (out_valid && word_n < 256) begin
      wdata_log[word_n] = out_data;
      wsof_log[word_n]  = out_sof;
      wcyc_log[word_n]  = cyc;
      word_n++;
    end
    if (eof && eof_n < 256) begin
      eok_log[eof_n]  = eof_ok;
      ecyc_log[eof_n] = cyc;
      eof_n++;
    end
    if (flag)  flag_n++;
    if (disc)  disc_n++;
    if (abort) abort_n++;
  end

  task automatic send_bit(input logic b);
    if (gap_mode) begin
      @(negedge clk);
      in_valid = 1'b0;
      in       = ~b;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in       = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_flag();
    send_byte(8'h7E);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in       = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    in       = 1'b0;
  endtask

  task automatic test_reset();
    int wb, fb, eb, ab;
    do_reset();
    checks++;
    if ({out_data, out_valid, out_sof, flag, disc, eof, eof_ok, abort} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {out_data, out_valid, out_sof, flag, disc, eof, eof_ok, abort});
    end
    wb = word_n; fb = flag_n; eb = eof_n; ab = abort_n;
    repeat (20) send_bit(1'b1);
    repeat (12) send_bit(1'b0);
    idle(4);
    checks++;
    if (word_n - wb != 0 || flag_n - fb != 0 || eof_n - eb != 0 || abort_n - ab != 0) begin
      failures++;
      $display("FAIL hunt_quiet got words=%0d flags=%0d eofs=%0d aborts=%0d want all 0",
               word_n - wb, flag_n - fb, eof_n - eb, abort_n - ab);
    end
  endtask

  task automatic test_good_frame(input bit gaps, input string tag);
    int wb, fb, eb;
    gap_mode = gaps;
    do_reset();
    wb = word_n; fb = flag_n; eb = eof_n;
    send_flag();
    send_byte(8'h12);
    send_byte(8'h34);
    send_flag();
    idle(4);
    gap_mode = 1'b0;
    checks++;
    if (word_n - wb != 2) begin
      failures++; $display("FAIL %s_word_count got=%0d want=2", tag, word_n - wb);
    end
    checks++;
    if (wdata_log[wb] !== 8'h12 || wsof_log[wb] !== 1'b1) begin
      failures++;
      $display("FAIL %s_word0 got=%h sof=%b want=12 sof=1", tag, wdata_log[wb], wsof_log[wb]);
    end
    checks++;
    if (wdata_log[wb+1] !== 8'h34 || wsof_log[wb+1] !== 1'b0) begin
      failures++;
      $display("FAIL %s_word1 got=%h sof=%b want=34 sof=0", tag, wdata_log[wb+1], wsof_log[wb+1]);
    end
    checks++;
    if (eof_n - eb != 1 || eok_log[eb] !== 1'b1) begin
      failures++;
      $display("FAIL %s_eof got count=%0d ok=%b want count=1 ok=1", tag, eof_n - eb, eok_log[eb]);
    end
    checks++;
    if (ecyc_log[eb] != wcyc_log[wb+1]) begin
      failures++;
      $display("FAIL %s_eof_cycle got=%0d want=%0d", tag, ecyc_log[eb], wcyc_log[wb+1]);
    end
    checks++;
    if (flag_n - fb != 2) begin
      failures++; $display("FAIL %s_flag_count got=%0d want=2", tag, flag_n - fb);
    end
  endtask

  task automatic test_stuffing();
    int wb, eb, db;
    do_reset();
    wb = word_n; eb = eof_n; db = disc_n;
    send_flag();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_byte(8'h12);
    send_flag();
    idle(4);
    checks++;
    if (disc_n - db != 1) begin
      failures++; $display("FAIL stuff_disc_count got=%0d want=1", disc_n - db);
    end
    checks++;
    if (word_n - wb != 2 || wdata_log[wb] !== 8'hFF || wsof_log[wb] !== 1'b1
        || wdata_log[wb+1] !== 8'h12) begin
      failures++;
      $display("FAIL stuff_words got n=%0d w0=%h sof=%b w1=%h want n=2 w0=ff sof=1 w1=12",
               word_n - wb, wdata_log[wb], wsof_log[wb], wdata_log[wb+1]);
    end
    checks++;
    if (eof_n - eb != 1 || eok_log[eb] !== 1'b1) begin
      failures++;
      $display("FAIL stuff_eof got count=%0d ok=%b want count=1 ok=1", eof_n - eb, eok_log[eb]);
    end
  endtask

  task automatic test_abort();
    int wb, eb, ab;
    do_reset();
    wb = word_n; eb = eof_n; ab = abort_n;
    send_flag();
    send_byte(8'h12);
    repeat (7) send_bit(1'b1);
    idle(3);
    checks++;
    if (abort_n - ab != 1 || eof_n - eb != 0 || word_n - wb != 0) begin
      failures++;
      $display("FAIL abort_pulse got aborts=%0d eofs=%0d words=%0d want 1/0/0",
               abort_n - ab, eof_n - eb, word_n - wb);
    end
    repeat (5) send_bit(1'b1);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(10);
    checks++;
    if (word_n - wb != 0 || eof_n - eb != 0 || abort_n - ab != 1) begin
      failures++;
      $display("FAIL abort_ignored got words=%0d eofs=%0d aborts=%0d want 0/0/1",
               word_n - wb, eof_n - eb, abort_n - ab);
    end
    send_flag();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_flag();
    idle(4);
    checks++;
    if (word_n - wb != 2 || wdata_log[wb] !== 8'hA5 || wsof_log[wb] !== 1'b1
        || wdata_log[wb+1] !== 8'h5A || wsof_log[wb+1] !== 1'b0) begin
      failures++;
      $display("FAIL abort_resume_words got n=%0d w0=%h/%b w1=%h/%b want 2 a5/1 5a/0",
               word_n - wb, wdata_log[wb], wsof_log[wb], wdata_log[wb+1], wsof_log[wb+1]);
    end
    checks++;
    if (eof_n - eb != 1 || eok_log[eb] !== 1'b1) begin
      failures++;
      $display("FAIL abort_resume_eof got count=%0d ok=%b want 1/1", eof_n - eb, eok_log[eb]);
    end
  endtask

  task automatic test_frame_edges();
    int wb, eb, fb;
    do_reset();
    wb = word_n; eb = eof_n;
    send_flag();
    send_byte(8'h12);
    send_byte(8'h34);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_flag();
    idle(4);
    checks++;
    if (word_n - wb != 2 || eof_n - eb != 1 || eok_log[eb] !== 1'b0) begin
      failures++;
      $display("FAIL misaligned got words=%0d eofs=%0d ok=%b want 2/1/0",
               word_n - wb, eof_n - eb, eok_log[eb]);
    end
    do_reset();
    wb = word_n; eb = eof_n;
    send_flag();
    send_byte(8'h12);
    send_flag();
    idle(4);
    checks++;
    if (word_n - wb != 1 || wdata_log[wb] !== 8'h12 || eof_n - eb != 1 || eok_log[eb] !== 1'b0) begin
      failures++;
      $display("FAIL runt got words=%0d w0=%h eofs=%0d ok=%b want 1/12/1/0",
               word_n - wb, wdata_log[wb], eof_n - eb, eok_log[eb]);
    end
    do_reset();
    wb = word_n; eb = eof_n; fb = flag_n;
    send_bit(1'b0);
    repeat (3) begin
      repeat (6) send_bit(1'b1);
      send_bit(1'b0);
    end
    idle(4);
    checks++;
    if (flag_n - fb != 3 || eof_n - eb != 0 || word_n - wb != 0) begin
      failures++;
      $display("FAIL shared_flags got flags=%0d eofs=%0d words=%0d want 3/0/0",
               flag_n - fb, eof_n - eb, word_n - wb);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wb, eb, ab;
    do_reset();
    wb = word_n; eb = eof_n; ab = abort_n;
    send_flag();
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    checks++;
    if (word_n - wb != 1 || wdata_log[wb] !== 8'h12) begin
      failures++;
      $display("FAIL midrst_pre got words=%0d w0=%h want 1/12", word_n - wb, wdata_log[wb]);
    end
    do_reset();
    checks++;
    if ({out_data, out_valid, out_sof, flag, disc, eof, eof_ok, abort} !== 15'h0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h want=0",
               {out_data, out_valid, out_sof, flag, disc, eof, eof_ok, abort});
    end
    send_byte(8'h56);
    send_byte(8'h78);
    idle(10);
    checks++;
    if (word_n - wb != 1 || eof_n - eb != 0 || abort_n - ab != 0) begin
      failures++;
      $display("FAIL midrst_quiet got words=%0d eofs=%0d aborts=%0d want 1/0/0",
               word_n - wb, eof_n - eb, abort_n - ab);
    end
    send_flag();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_flag();
    idle(4);
    checks++;
    if (word_n - wb != 3 || wdata_log[wb+1] !== 8'hA5 || wsof_log[wb+1] !== 1'b1
        || wdata_log[wb+2] !== 8'h5A || eof_n - eb != 1 || eok_log[eb] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_resume got words=%0d w=%h/%b %h eofs=%0d ok=%b want 3 a5/1 5a 1 1",
               word_n - wb, wdata_log[wb+1], wsof_log[wb+1], wdata_log[wb+2],
               eof_n - eb, eok_log[eb]);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame(1'b0, "good");
    test_stuffing();
    test_abort();
    test_frame_edges();
    test_good_frame(1'b1, "gaps");
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
